clock_divider_multi: RTL

Parametrised, multi-channel successor to the fixed-ratio clock divider. Each channel produces a registered, glitch-free divided clock-enable waveform and a one-cycle period tick. Each channel has a runtime-programmable divisor, applied glitch-free at the next period boundary. Channels have independent enables and share a global sync strobe for phase alignment. The block sits between the board clock and slower logic such as display scan, debounce and UART baud ticks.

---
 rtl/clock_divider_multi.sv | 103 ++++++++++
 1 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel emits a registered
// divided waveform and a period-start tick, with divisor changes taken at period boundaries.
module clock_divider_multi #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic [DIV_W-1:0]  div_in,
    input  logic [NUM_CH-1:0] div_load,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    // ceil(d/2) in one extra bit so the largest divisor cannot wrap
    function automatic logic [DIV_W:0] half_up(input logic [DIV_W-1:0] d);
        return ({1'b0, d} + (DIV_W+1)'(1)) >> 1;
    endfunction

    logic [DIV_W-1:0]  cnt        [NUM_CH];
    logic [DIV_W-1:0]  active_div [NUM_CH];
    logic [DIV_W-1:0]  shadow     [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] live;

    logic [DIV_W-1:0]  cnt_nx     [NUM_CH];
    logic [DIV_W-1:0]  act_nx     [NUM_CH];
    logic [DIV_W-1:0]  shadow_nx  [NUM_CH];
    logic [DIV_W-1:0]  next_div   [NUM_CH];
    logic [DIV_W-1:0]  div_force  [NUM_CH];
    logic [NUM_CH-1:0] pending_nx;
    logic [NUM_CH-1:0] live_nx;
    logic [NUM_CH-1:0] clk_nx;
    logic [NUM_CH-1:0] tick_nx;

    // live marks a channel already inside a period; a channel that is not live
    // treats its first enabled edge as a boundary so it starts at cnt=0 with a tick.
    always_comb begin
        pending_nx = pending | div_load;
        live_nx    = live;
        clk_nx     = '0;
        tick_nx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            next_div[i]  = div_load[i] ? div_in : (pending[i] ? shadow[i] : active_div[i]);
            shadow_nx[i] = div_load[i] ? div_in : shadow[i];
            cnt_nx[i]    = cnt[i];
            act_nx[i]    = active_div[i];
            div_force[i] = active_div[i];
            if (!en[i] || active_div[i] < TWO) begin
                cnt_nx[i]     = '0;
                act_nx[i]     = next_div[i];
                pending_nx[i] = 1'b0;
                live_nx[i]    = 1'b0;
                clk_nx[i]     = en[i] && (active_div[i] == ONE);
                tick_nx[i]    = en[i] && (active_div[i] == ONE);
            end else begin
                live_nx[i] = 1'b1;
                if (!live[i] || sync || cnt[i] == active_div[i] - ONE) begin
                    cnt_nx[i]     = '0;
                    act_nx[i]     = next_div[i];
                    pending_nx[i] = 1'b0;
                    div_force[i]  = next_div[i];
                end else begin
                    cnt_nx[i] = cnt[i] + ONE;
                end
                clk_nx[i]  = {1'b0, cnt_nx[i]} < half_up(div_force[i]);
                tick_nx[i] = (cnt_nx[i] == '0) && (div_force[i] != '0);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            live    <= '0;
            clk_out <= '0;
            tick    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]        <= '0;
                active_div[i] <= DIV_RST;
                shadow[i]     <= DIV_RST;
            end
        end else begin
            pending <= pending_nx;
            live    <= live_nx;
            clk_out <= clk_nx;
            tick    <= tick_nx;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]        <= cnt_nx[i];
                active_div[i] <= act_nx[i];
                shadow[i]     <= shadow_nx[i];
            end
        end
    end

endmodule
